// File: rtl/sram_pkg.sv
// Shared definitions for the masked two-port SRAM with zero-fill on reset.
//   DEF_*         default geometry (32 x 36, 9-bit mask lanes)
//   MERGE_W       widest entry the lane merge helper handles
//   init_state_e  zero-fill sequencer states
//   lane_merge    per-lane select between an old and a new entry
package sram_pkg;

    localparam int DEF_DEPTH     = 32;
    localparam int DEF_WIDTH     = 36;
    localparam int DEF_MASK_GRAN = 9;
    localparam int MERGE_W       = 1024;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } init_state_e;

    // Bit b takes new_val when the mask lane covering it (b / gran) is set.
    // Callers zero-extend narrower entries and keep the low bits.
    function automatic logic [MERGE_W-1:0] lane_merge(
        input logic [MERGE_W-1:0] old_val,
        input logic [MERGE_W-1:0] new_val,
        input logic [MERGE_W-1:0] mask,
        input int                 gran
    );
        logic [MERGE_W-1:0] res;
        for (int b = 0; b < MERGE_W; b++) begin
            res[b] = mask[b / gran] ? new_val[b] : old_val[b];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_rw_port_pipe.sv
// Read return pipeline for one SRAM port.
//   clock, reset  rising-edge clock, synchronous active-high reset (flushes all stages)
//   rd_fire       a read was accepted this cycle
//   rd_entry      entry value to return for that read
//   rdata/rvalid  returned data, 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1)
// rdata is forced to zero in every stage that does not carry a valid read.
module sram_rw_port_pipe #(
    parameter int WIDTH   = 36,
    parameter int OUT_REG = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rd_fire,
    input  logic [WIDTH-1:0] rd_entry,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_fire;
            s1_data  <= rd_fire ? rd_entry : '0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             s2_valid;
            logic [WIDTH-1:0] s2_data;

            always_ff @(posedge clock) begin
                if (reset) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    s2_data  <= s1_data;
                end
            end

            assign rdata  = s2_data;
            assign rvalid = s2_valid;
        end else begin : g_no_out_reg
            assign rdata  = s1_data;
            assign rvalid = s1_valid;
        end
    endgenerate

endmodule

// File: rtl/sram_2rw_masked_init.sv
// Two read/write port synchronous SRAM with per-lane write masks, selectable read
// latency, deterministic same-address collision rules and a zero-fill after reset.
//   clock, reset        rising-edge clock, synchronous active-high reset
//   init_done           high once every entry has been zeroed
//   dbg_state           zero-fill sequencer state
//   RWn_ready           port n accepts requests (equals init_done)
//   RWn_en/wmode        request valid; 1 = write, 0 = read
//   RWn_addr            entry address
//   RWn_wmask/wdata     lane write enables and write data
//   RWn_rdata/rvalid    read return, zero whenever rvalid is low
// Handshake: a request is taken on any rising edge where RWn_en and RWn_ready are
// both high; there is no backpressure once ready, and requests while not ready are
// dropped (no write, no read return).
module sram_2rw_masked_init
    import sram_pkg::*;
#(
    parameter  int DEPTH     = DEF_DEPTH,
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int MASK_GRAN = DEF_MASK_GRAN,
    parameter  int OUT_REG   = 0,
    parameter  int FWD_NEW   = 1,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int LANES     = WIDTH / MASK_GRAN
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_done,
    output init_state_e       dbg_state,
    output logic              RW0_ready,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic [LANES-1:0]  RW0_wmask,
    input  logic [WIDTH-1:0]  RW0_wdata,
    output logic [WIDTH-1:0]  RW0_rdata,
    output logic              RW0_rvalid,
    output logic              RW1_ready,
    input  logic              RW1_en,
    input  logic              RW1_wmode,
    input  logic [ADDR_W-1:0] RW1_addr,
    input  logic [LANES-1:0]  RW1_wmask,
    input  logic [WIDTH-1:0]  RW1_wdata,
    output logic [WIDTH-1:0]  RW1_rdata,
    output logic              RW1_rvalid
);

    logic [WIDTH-1:0] mem [DEPTH];

    init_state_e       state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;

    logic [ADDR_W-1:0] addr     [2];
    logic [LANES-1:0]  wmask    [2];
    logic [WIDTH-1:0]  wdata    [2];
    logic              wr_fire  [2];
    logic              rd_fire  [2];
    logic [WIDTH-1:0]  rd_entry [2];
    logic [WIDTH-1:0]  wr1_entry, wr0_entry;
    logic              same_addr;

    function automatic logic [WIDTH-1:0] merge(
        input logic [WIDTH-1:0] old_val,
        input logic [WIDTH-1:0] new_val,
        input logic [LANES-1:0] mask
    );
        logic [MERGE_W-1:0] wide;
        wide = lane_merge(MERGE_W'(old_val), MERGE_W'(new_val), MERGE_W'(mask), MASK_GRAN);
        return wide[WIDTH-1:0];
    endfunction

    // ---------------- zero-fill sequencer ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            INIT: begin
                // Two entries per cycle: ptr on port 0, ptr+1 on port 1.
                ptr_nx = ptr + ADDR_W'(2);
                if (ptr == ADDR_W'(DEPTH - 2)) begin
                    state_nx = RUN;
                end
            end
            RUN:     state_nx = RUN;
            default: state_nx = INIT;
        endcase
    end

    assign init_done = (state == RUN);
    assign dbg_state = state;
    assign RW0_ready = init_done;
    assign RW1_ready = init_done;

    // ---------------- request decode ----------------
    assign addr[0]  = RW0_addr;
    assign addr[1]  = RW1_addr;
    assign wmask[0] = RW0_wmask;
    assign wmask[1] = RW1_wmask;
    assign wdata[0] = RW0_wdata;
    assign wdata[1] = RW1_wdata;

    assign wr_fire[0] = init_done && RW0_en &&  RW0_wmode;
    assign wr_fire[1] = init_done && RW1_en &&  RW1_wmode;
    assign rd_fire[0] = init_done && RW0_en && !RW0_wmode;
    assign rd_fire[1] = init_done && RW1_en && !RW1_wmode;

    assign same_addr = (addr[0] == addr[1]);

    // Port 1 is merged first and port 0 on top, so port 0 wins overlapping lanes.
    always_comb begin
        wr1_entry = merge(mem[addr[1]], wdata[1], wmask[1]);
        wr0_entry = (wr_fire[1] && same_addr) ? wr1_entry : mem[addr[0]];
        wr0_entry = merge(wr0_entry, wdata[0], wmask[0]);
    end

    // Read-during-write forwarding: with FWD_NEW the reader sees the entry as it
    // will be after this cycle's writes. A port never reads and writes together,
    // so only the other port's write actually matters here.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_entry[p] = mem[addr[p]];
            if (FWD_NEW != 0) begin
                if (wr_fire[1] && addr[1] == addr[p]) begin
                    rd_entry[p] = merge(rd_entry[p], wdata[1], wmask[1]);
                end
                if (wr_fire[0] && addr[0] == addr[p]) begin
                    rd_entry[p] = merge(rd_entry[p], wdata[0], wmask[0]);
                end
            end
        end
    end

    // ---------------- storage ----------------
    // Contents are not reset directly; the INIT sweep zeroes them.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[ptr]               <= '0;
                mem[ptr + ADDR_W'(1)]  <= '0;
            end else begin
                if (wr_fire[1]) mem[addr[1]] <= wr1_entry;
                // Same address: port 0 result already contains port 1 lanes.
                if (wr_fire[0]) mem[addr[0]] <= wr0_entry;
            end
        end
    end

    // ---------------- read return ----------------
    sram_rw_port_pipe #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_pipe0 (
        .clock    (clock),
        .reset    (reset),
        .rd_fire  (rd_fire[0]),
        .rd_entry (rd_entry[0]),
        .rdata    (RW0_rdata),
        .rvalid   (RW0_rvalid)
    );

    sram_rw_port_pipe #(.WIDTH(WIDTH), .OUT_REG(OUT_REG)) u_pipe1 (
        .clock    (clock),
        .reset    (reset),
        .rd_fire  (rd_fire[1]),
        .rd_entry (rd_entry[1]),
        .rdata    (RW1_rdata),
        .rvalid   (RW1_rvalid)
    );

endmodule
